// File: rtl/raw_pkg.sv
// raw_pkg: shared defaults, FSM state encoding and test-pattern helper for the RAW line buffer.
//   DATA_W_DEF   default RAW pixel width
//   MAX_COLS_DEF default line buffer depth
//   state_t      frame/line protocol states
//   tpg_pattern  {col[4:0], row[4:0]} test pattern
package raw_pkg;

    localparam int DATA_W_DEF   = 10;
    localparam int MAX_COLS_DEF = 1280;

    typedef enum logic [1:0] {
        S_SYNC,
        S_VBLANK,
        S_HBLANK,
        S_ACTIVE
    } state_t;

    function automatic logic [9:0] tpg_pattern(input logic [4:0] col, input logic [4:0] row);
        return {col, row};
    endfunction

endpackage

// File: rtl/raw_line_ram.sv
// raw_line_ram: single-port line RAM, synchronous read returning old data on write.
//   CLK    clock
//   en     access enable: reads addr into q and writes wdata at addr
//   addr   column address
//   wdata  write data
//   q      registered read data, holds while en is low
// Storage has no reset so it maps onto one block RAM.
module raw_line_ram
    import raw_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int DEPTH  = MAX_COLS_DEF,
    parameter int ADDR_W = 11
) (
    input  logic              CLK,
    input  logic              en,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] q
);

    logic [DATA_W-1:0] mem [DEPTH];

    always_ff @(posedge CLK) begin
        if (en) begin
            mem[addr] <= wdata;
            q         <= mem[addr];
        end
    end

endmodule

// File: rtl/raw_line_buffer.sv
// raw_line_buffer: buffers one RAW line and emits vertically aligned pixel pairs with Bayer phase.
//   CLK, RESET_N          pixel clock, asynchronous active-low reset
//   IN_DATA/IN_LVAL/IN_FVAL  camera RAW stream
//   TPG_ON                replace pixels with {col[4:0], row[4:0]} (only when RAW_TPG_EN is defined)
//   D0, D1                current-line pixel and previous-line pixel of the same column
//   X, Y                  column / row parity of D0/D1
//   OUT_DV, OUT_SOF       output valid, first valid of a frame
//   FIRST_ROW             valid pixel belongs to row 0 (D1 forced to 0)
//   OVERFLOW              sticky per frame: a line exceeded MAX_COLS
// Optional feature macro: RAW_TPG_EN.
module raw_line_buffer
    import raw_pkg::*;
#(
    parameter int DATA_W   = DATA_W_DEF,
    parameter int MAX_COLS = MAX_COLS_DEF,
    parameter int ADDR_W   = 11,
    parameter int ROW_W    = 11
) (
    input  logic              CLK,
    input  logic              RESET_N,
    input  logic [DATA_W-1:0] IN_DATA,
    input  logic              IN_LVAL,
    input  logic              IN_FVAL,
`ifdef RAW_TPG_EN
    input  logic              TPG_ON,
`endif
    output logic [DATA_W-1:0] D0,
    output logic [DATA_W-1:0] D1,
    output logic              X,
    output logic              Y,
    output logic              OUT_DV,
    output logic              OUT_SOF,
    output logic              FIRST_ROW,
    output logic              OVERFLOW
);

    state_t            state, state_nx;
    // One extra bit so the counter can sit at MAX_COLS even when MAX_COLS == 2**ADDR_W.
    logic [ADDR_W:0]   col, col_nx;
    logic [ROW_W-1:0]  row, row_nx;
    logic              sof_pend;
    logic              d1_zero;
    logic [DATA_W-1:0] ram_q;
    logic [DATA_W-1:0] pix;
    logic              in_line, col_full, accept;

    assign in_line  = (state == S_HBLANK || state == S_ACTIVE) && IN_FVAL && IN_LVAL;
    assign col_full = col == (ADDR_W + 1)'(MAX_COLS);
    assign accept   = in_line && !col_full;

`ifdef RAW_TPG_EN
    assign pix = TPG_ON ? DATA_W'(tpg_pattern(col[4:0], row[4:0])) : IN_DATA;
`else
    assign pix = IN_DATA;
`endif

    always_comb begin
        state_nx = state;
        col_nx   = col;
        row_nx   = row;
        case (state)
            S_SYNC:   if (!IN_FVAL) state_nx = S_VBLANK;
            S_VBLANK: if (IN_FVAL) begin
                          state_nx = S_HBLANK;
                          col_nx   = '0;
                          row_nx   = '0;
                      end
            S_HBLANK: if (!IN_FVAL) state_nx = S_VBLANK;
                      else if (IN_LVAL) state_nx = S_ACTIVE;
            S_ACTIVE: if (!IN_FVAL) state_nx = S_VBLANK;
                      else if (!IN_LVAL) begin
                          state_nx = S_HBLANK;
                          col_nx   = '0;
                          row_nx   = &row ? row : row + 1'b1;
                      end
            default:  state_nx = S_SYNC;
        endcase
        if (accept) col_nx = col + 1'b1;
    end

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            state     <= S_SYNC;
            col       <= '0;
            row       <= '0;
            sof_pend  <= 1'b0;
            d1_zero   <= 1'b1;
            D0        <= '0;
            X         <= 1'b0;
            Y         <= 1'b0;
            OUT_DV    <= 1'b0;
            OUT_SOF   <= 1'b0;
            FIRST_ROW <= 1'b0;
            OVERFLOW  <= 1'b0;
        end else begin
            state     <= state_nx;
            col       <= col_nx;
            row       <= row_nx;
            OUT_DV    <= accept;
            OUT_SOF   <= accept && sof_pend;
            FIRST_ROW <= accept && row == '0;
            if (state == S_VBLANK && IN_FVAL) begin
                sof_pend <= 1'b1;
                OVERFLOW <= 1'b0;
            end else begin
                if (accept) sof_pend <= 1'b0;
                if (in_line && col_full) OVERFLOW <= 1'b1;
            end
            if (accept) begin
                D0      <= pix;
                X       <= col[0];
                Y       <= row[0];
                d1_zero <= row == '0;
            end
        end
    end

    raw_line_ram #(
        .DATA_W (DATA_W),
        .DEPTH  (MAX_COLS),
        .ADDR_W (ADDR_W)
    ) u_ram (
        .CLK   (CLK),
        .en    (accept),
        .addr  (col[ADDR_W-1:0]),
        .wdata (pix),
        .q     (ram_q)
    );

    // RAM output register holds between accepts, so gating it keeps D1 stable too.
    assign D1 = d1_zero ? '0 : ram_q;

endmodule

// File: tb/tb_raw_line_buffer.sv
// tb_raw_line_buffer: directed self-checking bench for raw_line_buffer.
module tb_raw_line_buffer;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [9:0] in_data = '0;
    logic       in_lval = 1'b0;
    logic       in_fval = 1'b1;
`ifdef RAW_TPG_EN
    logic       tpg_on = 1'b0;
`endif
    logic [9:0] d0, d1;
    logic       x, y, out_dv, out_sof, first_row, overflow;
    int         total = 0;
    int         bad = 0;

    always #5 clk = ~clk;

    raw_line_buffer dut (
        .CLK       (clk),
        .RESET_N   (rst_n),
        .IN_DATA   (in_data),
        .IN_LVAL   (in_lval),
        .IN_FVAL   (in_fval),
`ifdef RAW_TPG_EN
        .TPG_ON    (tpg_on),
`endif
        .D0        (d0),
        .D1        (d1),
        .X         (x),
        .Y         (y),
        .OUT_DV    (out_dv),
        .OUT_SOF   (out_sof),
        .FIRST_ROW (first_row),
        .OVERFLOW  (overflow)
    );

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic step(input logic [9:0] d, input logic l, input logic f);
        @(negedge clk);
        in_data = d;
        in_lval = l;
        in_fval = f;
        @(posedge clk);
        #1;
    endtask

    task automatic start_frame();
        step(10'h0, 1'b0, 1'b0);
        step(10'h0, 1'b0, 1'b1);
        step(10'h0, 1'b0, 1'b1);
    endtask

    task automatic end_frame();
        step(10'h0, 1'b0, 1'b1);
        step(10'h0, 1'b0, 1'b0);
        step(10'h0, 1'b0, 1'b0);
    endtask

    task automatic test_reset();
        int dv_cnt, sof_cnt;
        logic sof_first;
        repeat (3) @(negedge clk);
        total++; if (d0 !== 10'h0 || d1 !== 10'h0) begin bad++; $display("FAIL reset data d0=%h d1=%h want 0", d0, d1); end
        total++; if ({x, y, out_dv, out_sof, first_row, overflow} !== 6'b0) begin bad++; $display("FAIL reset flags got %b want 000000", {x, y, out_dv, out_sof, first_row, overflow}); end
        @(negedge clk);
        rst_n = 1'b1;
        dv_cnt = 0;
        for (int r = 0; r < 3; r++) begin
            for (int c = 0; c < 6; c++) begin
                step(10'(c), 1'b1, 1'b1);
                dv_cnt += int'(out_dv);
            end
            step(10'h0, 1'b0, 1'b1);
            dv_cnt += int'(out_dv);
        end
        total++; if (dv_cnt !== 0) begin bad++; $display("FAIL reset midframe dv count got %0d want 0", dv_cnt); end
        start_frame();
        dv_cnt = 0;
        sof_cnt = 0;
        sof_first = 1'b0;
        for (int c = 0; c < 4; c++) begin
            step(10'(c), 1'b1, 1'b1);
            dv_cnt += int'(out_dv);
            sof_cnt += int'(out_sof);
            if (c == 0) sof_first = out_sof;
        end
        end_frame();
        total++; if (dv_cnt !== 4) begin bad++; $display("FAIL reset first frame dv count got %0d want 4", dv_cnt); end
        total++; if (sof_cnt !== 1 || sof_first !== 1'b1) begin bad++; $display("FAIL reset sof count=%0d first=%b want 1/1", sof_cnt, sof_first); end
    endtask

    task automatic test_frame();
        logic [9:0] e;
        start_frame();
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 8; c++) begin
                step(10'(r * 16 + c), 1'b1, 1'b1);
                e = (r == 0) ? 10'h0 : 10'((r - 1) * 16 + c);
                total++; if (out_dv !== 1'b1) begin bad++; $display("FAIL frame dv r%0d c%0d got %b want 1", r, c, out_dv); end
                total++; if (d0 !== 10'(r * 16 + c)) begin bad++; $display("FAIL frame d0 r%0d c%0d got %h want %h", r, c, d0, 10'(r * 16 + c)); end
                total++; if (d1 !== e) begin bad++; $display("FAIL frame d1 r%0d c%0d got %h want %h", r, c, d1, e); end
                total++; if (x !== 1'(c) || y !== 1'(r)) begin bad++; $display("FAIL frame xy r%0d c%0d got %b%b want %b%b", r, c, x, y, 1'(c), 1'(r)); end
                total++; if (first_row !== (r == 0)) begin bad++; $display("FAIL frame first_row r%0d c%0d got %b", r, c, first_row); end
                total++; if (out_sof !== (r == 0 && c == 0)) begin bad++; $display("FAIL frame sof r%0d c%0d got %b", r, c, out_sof); end
            end
            step(10'h3FF, 1'b0, 1'b1);
            total++; if (out_dv !== 1'b0 || d0 !== 10'(r * 16 + 7)) begin bad++; $display("FAIL frame hold r%0d dv=%b d0=%h want 0/%h", r, out_dv, d0, 10'(r * 16 + 7)); end
        end
        total++; if (overflow !== 1'b0) begin bad++; $display("FAIL frame overflow got %b want 0", overflow); end
        end_frame();
    endtask

    task automatic test_overflow();
        start_frame();
        for (int c = 0; c < 1283; c++) begin
            step(10'(c), 1'b1, 1'b1);
            if (c == 0 || c == 1279 || c >= 1280) begin
                total++; if (out_dv !== (c < 1280)) begin bad++; $display("FAIL ovf dv c%0d got %b want %b", c, out_dv, c < 1280); end
                total++; if (overflow !== (c >= 1280)) begin bad++; $display("FAIL ovf flag c%0d got %b want %b", c, overflow, c >= 1280); end
            end
            if (c == 1279) begin
                total++; if (d0 !== 10'h0FF) begin bad++; $display("FAIL ovf last d0 got %h want 0ff", d0); end
            end
        end
        step(10'h0, 1'b0, 1'b1);
        for (int c = 0; c < 4; c++) begin
            step(10'(10'h200 + c), 1'b1, 1'b1);
            total++; if (out_dv !== 1'b1 || d1 !== 10'(c) || overflow !== 1'b1) begin bad++; $display("FAIL ovf row1 c%0d dv=%b d1=%h ovf=%b want 1/%h/1", c, out_dv, d1, overflow, 10'(c)); end
        end
        end_frame();
        total++; if (overflow !== 1'b1) begin bad++; $display("FAIL ovf after frame got %b want 1", overflow); end
        step(10'h0, 1'b0, 1'b1);
        total++; if (overflow !== 1'b0) begin bad++; $display("FAIL ovf clear on fval rise got %b want 0", overflow); end
        step(10'h0, 1'b0, 1'b0);
    endtask

    task automatic test_fval_fall();
        start_frame();
        for (int c = 0; c < 8; c++) step(10'(10'h100 + c), 1'b1, 1'b1);
        step(10'h0, 1'b0, 1'b1);
        for (int c = 0; c < 3; c++) begin
            step(10'(10'h110 + c), 1'b1, 1'b1);
            total++; if (d0 !== 10'(10'h110 + c) || d1 !== 10'(10'h100 + c)) begin bad++; $display("FAIL fall row1 c%0d d0=%h d1=%h", c, d0, d1); end
        end
        step(10'h1FF, 1'b0, 1'b0);
        total++; if (out_dv !== 1'b0 || d0 !== 10'h112) begin bad++; $display("FAIL fall edge dv=%b d0=%h want 0/112", out_dv, d0); end
        step(10'h1EE, 1'b1, 1'b0);
        total++; if (out_dv !== 1'b0) begin bad++; $display("FAIL fall lval after end dv=%b want 0", out_dv); end
        start_frame();
        for (int c = 0; c < 2; c++) begin
            step(10'(10'h120 + c), 1'b1, 1'b1);
            total++; if (first_row !== 1'b1 || y !== 1'b0 || d1 !== 10'h0) begin bad++; $display("FAIL fall next frame c%0d fr=%b y=%b d1=%h want 1/0/0", c, first_row, y, d1); end
            total++; if (out_sof !== (c == 0)) begin bad++; $display("FAIL fall next frame sof c%0d got %b", c, out_sof); end
        end
        end_frame();
    endtask

    task automatic test_ignore_lval();
        logic [9:0] e;
        start_frame();
        for (int c = 0; c < 8; c++) step(10'(10'h050 + c), 1'b1, 1'b1);
        step(10'h0, 1'b0, 1'b1);
        for (int c = 0; c < 8; c++) step(10'(10'h060 + c), 1'b1, 1'b1);
        step(10'h0, 1'b0, 1'b1);
        for (int i = 0; i < 8; i++) begin
            step(10'h3FF, 1'b1, 1'b0);
            total++; if (out_dv !== 1'b0) begin bad++; $display("FAIL ignore dv i%0d got %b want 0", i, out_dv); end
        end
        step(10'h0, 1'b0, 1'b0);
        start_frame();
        for (int c = 0; c < 4; c++) step(10'(10'h070 + c), 1'b1, 1'b1);
        step(10'h0, 1'b0, 1'b1);
        for (int c = 0; c < 8; c++) begin
            step(10'(10'h080 + c), 1'b1, 1'b1);
            e = (c < 4) ? 10'(10'h070 + c) : 10'(10'h060 + c);
            total++; if (d1 !== e) begin bad++; $display("FAIL ignore d1 c%0d got %h want %h", c, d1, e); end
        end
        end_frame();
    endtask

`ifdef RAW_TPG_EN
    task automatic test_tpg();
        logic [9:0] e;
        start_frame();
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 4; c++) begin
                tpg_on = !(r == 3 && c == 3);
                step(10'h3AA, 1'b1, 1'b1);
                e = tpg_on ? {5'(c), 5'(r)} : 10'h3AA;
                total++; if (d0 !== e) begin bad++; $display("FAIL tpg d0 r%0d c%0d got %h want %h", r, c, d0, e); end
                if (r == 3 && c == 2) begin
                    total++; if (d0 !== 10'h043) begin bad++; $display("FAIL tpg r3c2 got %h want 043", d0); end
                end
            end
            step(10'h0, 1'b0, 1'b1);
        end
        tpg_on = 1'b0;
        end_frame();
    endtask
`endif

    initial begin
        test_reset();
        test_frame();
        test_overflow();
        test_fval_fall();
        test_ignore_lval();
`ifdef RAW_TPG_EN
        test_tpg();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
